// File: rtl/mixed_radix_addr_seq.sv
// Mixed-radix address sequencer for a frame of N = 2^e2 * 3^e3 * 5^e5 points.
//
// A start in IDLE latches the configuration. CALC builds P2/P3/P5 one factor per cycle.
// PROD forms N and the per-pass strides and rejects frames that do not fit the address space.
// RUN streams addresses under a valid/accept handshake.
// Mode 0 runs up to three stride-permuted passes (radix 5, 3, 2). Each pass walks
// addr = x + c*M with inner index c over P and outer index x over M = N/P.
// Mode 1 runs one natural 0..N-1 pass.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   start_i         single-cycle frame request (honoured in IDLE only)
//   mode_i          0 = radix passes, 1 = linear pass
//   e2_i/e3_i/e5_i  radix exponents
//   adv_i           consumer accepts the current address
//   abort_i         cancel the frame (wins over adv_i)
//   addr_o          current address, qualified by addr_vld_o
//   pass_radix_o    00 linear, 01 radix-5, 10 radix-3, 11 radix-2
//   pass_last_o     current address closes its pass
//   frame_last_o    current address closes the frame
//   busy_o          frame in progress
//   done_o          one-cycle pulse after the last address is accepted
//   cfg_err_o       one-cycle pulse when N is out of range
//   n_points_o      last accepted frame size N
module mixed_radix_addr_seq #(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned E2_W   = 4,
    parameter int unsigned E3_W   = 3,
    parameter int unsigned E5_W   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              mode_i,
    input  logic [E2_W-1:0]   e2_i,
    input  logic [E3_W-1:0]   e3_i,
    input  logic [E5_W-1:0]   e5_i,
    input  logic              adv_i,
    input  logic              abort_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              addr_vld_o,
    output logic [1:0]        pass_radix_o,
    output logic              pass_last_o,
    output logic              frame_last_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              cfg_err_o,
    output logic [ADDR_W:0]   n_points_o
);

    // CW holds counts up to 2^ADDR_W.
    // PW leaves headroom for one x5 step above the saturation point.
    localparam int unsigned CW = ADDR_W + 1;
    localparam int unsigned PW = ADDR_W + 4;
    localparam int unsigned NW = 3 * PW;
    localparam logic [PW-1:0] PLim = PW'(2 ** ADDR_W);
    localparam logic [NW-1:0] NLim = NW'(2 ** ADDR_W);

    localparam logic [1:0] RadLin = 2'b00;
    localparam logic [1:0] Rad5   = 2'b01;
    localparam logic [1:0] Rad3   = 2'b10;
    localparam logic [1:0] Rad2   = 2'b11;

    typedef enum logic [1:0] {StIdle, StCalc, StProd, StRun} state_e;

    state_e            state_q, state_d;
    logic              mode_q, mode_d;
    logic [E2_W-1:0]   e2_q, e2_d;
    logic [E3_W-1:0]   e3_q, e3_d;
    logic [E5_W-1:0]   e5_q, e5_d;
    logic [PW-1:0]     p2_q, p2_d, p3_q, p3_d, p5_q, p5_d;
    logic [CW-1:0]     n_q, n_d;
    logic [CW-1:0]     m5_q, m5_d, m3_q, m3_d, m2_q, m2_d;
    logic [1:0]        radix_q, radix_d;
    logic [CW-1:0]     p_cur_q, p_cur_d, m_cur_q, m_cur_d;
    logic [CW-1:0]     x_q, x_d, c_q, c_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              vld_q, vld_d;
    logic              last_pass_q, last_pass_d;
    logic              pass_last_q, pass_last_d;
    logic              frame_last_q, frame_last_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              cfg_err_q, cfg_err_d;

    // Any factor beyond 2^ADDR_W already makes N invalid.
    // Clamping just above the limit keeps the multiply chain narrow.
    function automatic logic [PW-1:0] sat(input logic [PW-1:0] v);
        return (v > PLim) ? (PLim + PW'(1)) : v;
    endfunction

    function automatic logic [CW-1:0] pass_size(input logic [1:0] r, input logic [CW-1:0] n,
                                                input logic [CW-1:0] p5, input logic [CW-1:0] p3,
                                                input logic [CW-1:0] p2);
        case (r)
            Rad5:    return p5;
            Rad3:    return p3;
            Rad2:    return p2;
            default: return n;
        endcase
    endfunction

    function automatic logic [CW-1:0] pass_stride(input logic [1:0] r, input logic [CW-1:0] m5,
                                                  input logic [CW-1:0] m3,
                                                  input logic [CW-1:0] m2);
        case (r)
            Rad5:    return m5;
            Rad3:    return m3;
            Rad2:    return m2;
            default: return CW'(1);
        endcase
    endfunction

    // A pass is final when no later radix in the 5 -> 3 -> 2 order has a factor above 1.
    function automatic logic pass_is_last(input logic [1:0] r, input logic p3_one,
                                          input logic p2_one);
        case (r)
            Rad5:    return p3_one && p2_one;
            Rad3:    return p2_one;
            default: return 1'b1;
        endcase
    endfunction

    // Frame-size products, used only in PROD.
    logic [NW-1:0] p2_x, p3_x, p5_x, n_full;
    logic [CW-1:0] p2_t, p3_t, p5_t, n_c, m5_c, m3_c, m2_c;
    logic          cfg_bad, p3_one, p2_one;
    logic [1:0]    init_radix, next_radix;

    assign p2_x   = NW'(p2_q);
    assign p3_x   = NW'(p3_q);
    assign p5_x   = NW'(p5_q);
    assign n_full = p2_x * p3_x * p5_x;
    assign p2_t   = p2_q[CW-1:0];
    assign p3_t   = p3_q[CW-1:0];
    assign p5_t   = p5_q[CW-1:0];
    assign n_c    = n_full[CW-1:0];
    // Truncation is harmless: strides are only kept when N itself fits.
    assign m5_c   = p3_t * p2_t;
    assign m3_c   = p5_t * p2_t;
    assign m2_c   = p5_t * p3_t;
    assign cfg_bad = (n_full < NW'(2)) || (n_full > NLim);
    assign p3_one  = (p3_q == PW'(1));
    assign p2_one  = (p2_q == PW'(1));

    assign init_radix = mode_q            ? RadLin :
                        (p5_q != PW'(1))  ? Rad5   :
                        !p3_one           ? Rad3   : Rad2;
    // Only consulted when the current pass is not final, so a later pass exists.
    assign next_radix = ((radix_q == Rad5) && !p3_one) ? Rad3 : Rad2;

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        e2_d        = e2_q;
        e3_d        = e3_q;
        e5_d        = e5_q;
        p2_d        = p2_q;
        p3_d        = p3_q;
        p5_d        = p5_q;
        n_d         = n_q;
        m5_d        = m5_q;
        m3_d        = m3_q;
        m2_d        = m2_q;
        radix_d     = radix_q;
        p_cur_d     = p_cur_q;
        m_cur_d     = m_cur_q;
        x_d         = x_q;
        c_d         = c_q;
        addr_d      = addr_q;
        vld_d       = vld_q;
        last_pass_d = last_pass_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        cfg_err_d   = 1'b0;

        if (abort_i && (state_q != StIdle)) begin
            state_d = StIdle;
            vld_d   = 1'b0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    // A start coinciding with the done pulse is dropped.
                    if (start_i && !done_q) begin
                        mode_d  = mode_i;
                        e2_d    = e2_i;
                        e3_d    = e3_i;
                        e5_d    = e5_i;
                        p2_d    = PW'(1);
                        p3_d    = PW'(1);
                        p5_d    = PW'(1);
                        busy_d  = 1'b1;
                        state_d = StCalc;
                    end
                end
                StCalc: begin
                    if (e2_q != '0) begin
                        e2_d = e2_q - E2_W'(1);
                        p2_d = sat(p2_q << 1);
                    end
                    if (e3_q != '0) begin
                        e3_d = e3_q - E3_W'(1);
                        p3_d = sat(p3_q + (p3_q << 1));
                    end
                    if (e5_q != '0) begin
                        e5_d = e5_q - E5_W'(1);
                        p5_d = sat(p5_q + (p5_q << 2));
                    end
                    // Leave once this cycle consumes the last factor (at least one cycle).
                    if ((e2_q <= E2_W'(1)) && (e3_q <= E3_W'(1)) && (e5_q <= E5_W'(1))) begin
                        state_d = StProd;
                    end
                end
                StProd: begin
                    if (cfg_bad) begin
                        cfg_err_d = 1'b1;
                        busy_d    = 1'b0;
                        state_d   = StIdle;
                    end else begin
                        n_d         = n_c;
                        m5_d        = m5_c;
                        m3_d        = m3_c;
                        m2_d        = m2_c;
                        radix_d     = init_radix;
                        p_cur_d     = pass_size(init_radix, n_c, p5_t, p3_t, p2_t);
                        m_cur_d     = pass_stride(init_radix, m5_c, m3_c, m2_c);
                        last_pass_d = pass_is_last(init_radix, p3_one, p2_one);
                        x_d         = '0;
                        c_d         = '0;
                        addr_d      = '0;
                        vld_d       = 1'b1;
                        state_d     = StRun;
                    end
                end
                StRun: begin
                    if (adv_i) begin
                        if (frame_last_q) begin
                            vld_d   = 1'b0;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            state_d = StIdle;
                        end else if (pass_last_q) begin
                            radix_d     = next_radix;
                            p_cur_d     = pass_size(next_radix, n_q, p5_t, p3_t, p2_t);
                            m_cur_d     = pass_stride(next_radix, m5_q, m3_q, m2_q);
                            last_pass_d = pass_is_last(next_radix, p3_one, p2_one);
                            x_d         = '0;
                            c_d         = '0;
                            addr_d      = '0;
                        end else if (c_q == (p_cur_q - CW'(1))) begin
                            // Inner wrap: restart the column at the next outer index.
                            c_d    = '0;
                            x_d    = x_q + CW'(1);
                            addr_d = ADDR_W'(x_q + CW'(1));
                        end else begin
                            c_d    = c_q + CW'(1);
                            addr_d = addr_q + m_cur_q[ADDR_W-1:0];
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        // Flags describe the address that will be presented next cycle.
        pass_last_d  = vld_d && (c_d == (p_cur_d - CW'(1))) && (x_d == (m_cur_d - CW'(1)));
        frame_last_d = pass_last_d && last_pass_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            mode_q       <= 1'b0;
            e2_q         <= '0;
            e3_q         <= '0;
            e5_q         <= '0;
            p2_q         <= '0;
            p3_q         <= '0;
            p5_q         <= '0;
            n_q          <= '0;
            m5_q         <= '0;
            m3_q         <= '0;
            m2_q         <= '0;
            radix_q      <= 2'b00;
            p_cur_q      <= '0;
            m_cur_q      <= '0;
            x_q          <= '0;
            c_q          <= '0;
            addr_q       <= '0;
            vld_q        <= 1'b0;
            last_pass_q  <= 1'b0;
            pass_last_q  <= 1'b0;
            frame_last_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            e2_q         <= e2_d;
            e3_q         <= e3_d;
            e5_q         <= e5_d;
            p2_q         <= p2_d;
            p3_q         <= p3_d;
            p5_q         <= p5_d;
            n_q          <= n_d;
            m5_q         <= m5_d;
            m3_q         <= m3_d;
            m2_q         <= m2_d;
            radix_q      <= radix_d;
            p_cur_q      <= p_cur_d;
            m_cur_q      <= m_cur_d;
            x_q          <= x_d;
            c_q          <= c_d;
            addr_q       <= addr_d;
            vld_q        <= vld_d;
            last_pass_q  <= last_pass_d;
            pass_last_q  <= pass_last_d;
            frame_last_q <= frame_last_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    assign addr_o       = addr_q;
    assign addr_vld_o   = vld_q;
    assign pass_radix_o = radix_q;
    assign pass_last_o  = pass_last_q;
    assign frame_last_o = frame_last_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign cfg_err_o    = cfg_err_q;
    assign n_points_o   = n_q;

endmodule

// File: tb/tb_mixed_radix_addr_seq.sv
// Directed self-checking bench for mixed_radix_addr_seq.
module tb_mixed_radix_addr_seq;

    localparam int ADDR_W = 11;
    localparam int E2_W   = 4;
    localparam int E3_W   = 3;
    localparam int E5_W   = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              start_i, mode_i, adv_i, abort_i;
    logic [E2_W-1:0]   e2_i;
    logic [E3_W-1:0]   e3_i;
    logic [E5_W-1:0]   e5_i;
    logic [ADDR_W-1:0] addr_o;
    logic              addr_vld_o, pass_last_o, frame_last_o, busy_o, done_o, cfg_err_o;
    logic [1:0]        pass_radix_o;
    logic [ADDR_W:0]   n_points_o;

    int errors = 0;
    int checks = 0;

    int got_addr[$];
    int got_rad[$];
    bit got_pl[$];
    bit got_fl[$];
    int exp_addr[$];
    int exp_rad[$];
    bit exp_pl[$];
    bit exp_fl[$];

    int done_extra, hold_bad;
    bit done_at_end, busy_at_end, vld_at_end, timed_out;

    mixed_radix_addr_seq #(
        .ADDR_W(ADDR_W),
        .E2_W  (E2_W),
        .E3_W  (E3_W),
        .E5_W  (E5_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .mode_i      (mode_i),
        .e2_i        (e2_i),
        .e3_i        (e3_i),
        .e5_i        (e5_i),
        .adv_i       (adv_i),
        .abort_i     (abort_i),
        .addr_o      (addr_o),
        .addr_vld_o  (addr_vld_o),
        .pass_radix_o(pass_radix_o),
        .pass_last_o (pass_last_o),
        .frame_last_o(frame_last_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .cfg_err_o   (cfg_err_o),
        .n_points_o  (n_points_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Drive a one-cycle start; returns at the negedge after the sampling edge.
    task automatic do_start(input bit m, input int a2, input int a3, input int a5);
        @(negedge clk);
        start_i = 1'b1;
        mode_i  = m;
        e2_i    = E2_W'(a2);
        e3_i    = E3_W'(a3);
        e5_i    = E5_W'(a5);
        @(negedge clk);
        start_i = 1'b0;
    endtask

    // Edges since the start-sampling edge until addr_vld is seen (limit 60).
    task automatic wait_vld(output int lat);
        lat = 0;
        while (!addr_vld_o && lat < 60) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // Reference order written directly as addr = x + c*M.
    task automatic gen_expected(input bit m, input int a2, input int a3, input int a5);
        int p2, p3, p5, n, np;
        int pr[3];
        int pp[3];
        exp_addr.delete(); exp_rad.delete(); exp_pl.delete(); exp_fl.delete();
        p2 = 1; repeat (a2) p2 = p2 * 2;
        p3 = 1; repeat (a3) p3 = p3 * 3;
        p5 = 1; repeat (a5) p5 = p5 * 5;
        n = p2 * p3 * p5;
        if (m) begin
            for (int i = 0; i < n; i++) begin
                exp_addr.push_back(i); exp_rad.push_back(0);
                exp_pl.push_back(i == n - 1); exp_fl.push_back(i == n - 1);
            end
        end else begin
            np = 0;
            if (a5 > 0) begin pr[np] = 1; pp[np] = p5; np++; end
            if (a3 > 0) begin pr[np] = 2; pp[np] = p3; np++; end
            if (a2 > 0) begin pr[np] = 3; pp[np] = p2; np++; end
            for (int k = 0; k < np; k++) begin
                int mm;
                mm = n / pp[k];
                for (int x = 0; x < mm; x++) begin
                    for (int c = 0; c < pp[k]; c++) begin
                        bit pl;
                        pl = (x == mm - 1) && (c == pp[k] - 1);
                        exp_addr.push_back(x + c * mm);
                        exp_rad.push_back(pr[k]);
                        exp_pl.push_back(pl);
                        exp_fl.push_back(pl && (k == np - 1));
                    end
                end
            end
        end
    endtask

    // Accept addresses until frame_last is taken; records what was seen.
    task automatic collect(input bit rnd, input int budget);
        bit fin, held, a, ppl, pfl;
        int cyc, paddr, prad;
        got_addr.delete(); got_rad.delete(); got_pl.delete(); got_fl.delete();
        fin = 0; held = 0; cyc = 0; done_extra = 0; hold_bad = 0;
        paddr = 0; prad = 0; ppl = 0; pfl = 0;
        while (!fin && cyc < budget) begin
            if (done_o) done_extra++;
            if (held && (!addr_vld_o || int'(addr_o) != paddr || int'(pass_radix_o) != prad ||
                         pass_last_o != ppl || frame_last_o != pfl)) hold_bad++;
            held = 0;
            if (addr_vld_o) begin
                a = rnd ? ($urandom_range(1) == 1) : 1'b1;
                adv_i = a;
                if (a) begin
                    got_addr.push_back(int'(addr_o));
                    got_rad.push_back(int'(pass_radix_o));
                    got_pl.push_back(pass_last_o);
                    got_fl.push_back(frame_last_o);
                    if (frame_last_o) fin = 1;
                end else begin
                    held = 1; paddr = int'(addr_o); prad = int'(pass_radix_o);
                    ppl = pass_last_o; pfl = frame_last_o;
                end
            end else begin
                adv_i = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        adv_i = 1'b0;
        timed_out   = !fin;
        done_at_end = done_o;
        busy_at_end = busy_o;
        vld_at_end  = addr_vld_o;
        repeat (3) begin
            @(negedge clk);
            if (done_o) done_extra++;
        end
    endtask

    task automatic seq_mismatch(output int bad, output int first);
        int len;
        bad = 0; first = -1;
        len = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
        for (int i = 0; i < len; i++) begin
            if (got_addr[i] != exp_addr[i] || got_rad[i] != exp_rad[i] ||
                got_pl[i] != exp_pl[i] || got_fl[i] != exp_fl[i]) begin
                if (first < 0) first = i;
                bad++;
            end
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({addr_o, addr_vld_o, pass_radix_o, pass_last_o, frame_last_o, busy_o, done_o,
             cfg_err_o, n_points_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: addr=%0d vld=%b rad=%0d busy=%b n=%0d want all 0",
                     addr_o, addr_vld_o, pass_radix_o, busy_o, n_points_o);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b0 || addr_vld_o !== 1'b0 || n_points_o !== '0) begin
            errors++;
            $display("FAIL reset_release: busy=%b vld=%b n=%0d want 0", busy_o, addr_vld_o,
                     n_points_o);
        end
    endtask

    task automatic test_mode0_n30();
        int lat, bad, first;
        int hidx[18] = '{0, 1, 2, 3, 4, 5, 6, 30, 31, 32, 33, 34, 60, 61, 62, 63, 88, 89};
        int hval[18] = '{0, 6, 12, 18, 24, 1, 7, 0, 10, 20, 1, 11, 0, 15, 1, 16, 14, 29};
        do_start(1'b0, 1, 1, 1);
        wait_vld(lat);
        checks++;
        if (lat != 2) begin
            errors++; $display("FAIL n30_latency: got %0d want 2", lat);
        end
        checks++;
        if (n_points_o !== 12'd30 || pass_radix_o !== 2'b01 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL n30_first: n=%0d rad=%0d busy=%b want 30 1 1", n_points_o,
                     pass_radix_o, busy_o);
        end
        collect(1'b0, 500);
        gen_expected(1'b0, 1, 1, 1);
        checks++;
        if (timed_out || got_addr.size() != 90) begin
            errors++; $display("FAIL n30_count: got %0d want 90", got_addr.size());
        end
        seq_mismatch(bad, first);
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL n30_sequence: %0d bad, first at %0d", bad, first);
        end
        for (int i = 0; i < 18; i++) begin
            checks++;
            if (hidx[i] >= got_addr.size() || got_addr[hidx[i]] != hval[i]) begin
                errors++;
                $display("FAIL n30_addr[%0d]: got %0d want %0d", hidx[i],
                         (hidx[i] < got_addr.size()) ? got_addr[hidx[i]] : -1, hval[i]);
            end
        end
        checks++;
        if (got_rad.size() < 61 || got_rad[0] != 1 || got_rad[30] != 2 || got_rad[60] != 3) begin
            errors++; $display("FAIL n30_radix_order: pass radix order wrong");
        end
        checks++;
        if (done_at_end !== 1'b1 || done_extra != 0) begin
            errors++;
            $display("FAIL n30_done: at_end=%b extra=%0d want 1 0", done_at_end, done_extra);
        end
        checks++;
        if (busy_at_end !== 1'b0 || vld_at_end !== 1'b0) begin
            errors++;
            $display("FAIL n30_idle: busy=%b vld=%b want 0 0", busy_at_end, vld_at_end);
        end
    endtask

    task automatic test_cfg_err();
        int a2s[3] = '{9, 0, 15};
        int a3s[3] = '{2, 0, 7};
        int a5s[3] = '{0, 0, 3};
        int cfirst[3] = '{10, 2, 16};
        for (int v = 0; v < 3; v++) begin
            int ccnt, vcnt, dcnt, at;
            ccnt = 0; vcnt = 0; dcnt = 0; at = -1;
            do_start(1'b0, a2s[v], a3s[v], a5s[v]);
            checks++;
            if (busy_o !== 1'b1) begin
                errors++; $display("FAIL cfg%0d_busy_calc: got %b want 1", v, busy_o);
            end
            for (int k = 0; k < 25; k++) begin
                if (cfg_err_o) begin ccnt++; if (at < 0) at = k; end
                if (addr_vld_o) vcnt++;
                if (done_o) dcnt++;
                @(negedge clk);
            end
            checks++;
            if (ccnt != 1 || vcnt != 0 || dcnt != 0) begin
                errors++;
                $display("FAIL cfg%0d_pulse: cfg=%0d vld=%0d done=%0d want 1 0 0", v, ccnt, vcnt,
                         dcnt);
            end
            checks++;
            if (at != cfirst[v]) begin
                errors++; $display("FAIL cfg%0d_timing: got %0d want %0d", v, at, cfirst[v]);
            end
            checks++;
            if (busy_o !== 1'b0) begin
                errors++; $display("FAIL cfg%0d_busy_after: got %b want 0", v, busy_o);
            end
        end
    endtask

    task automatic test_linear();
        int lat, bad, first;
        do_start(1'b1, 2, 1, 0);
        wait_vld(lat);
        checks++;
        if (lat != 3 || n_points_o !== 12'd12 || pass_radix_o !== 2'b00) begin
            errors++;
            $display("FAIL lin_start: lat=%0d n=%0d rad=%0d want 3 12 0", lat, n_points_o,
                     pass_radix_o);
        end
        collect(1'b0, 200);
        gen_expected(1'b1, 2, 1, 0);
        checks++;
        if (timed_out || got_addr.size() != 12) begin
            errors++; $display("FAIL lin_count: got %0d want 12", got_addr.size());
        end
        seq_mismatch(bad, first);
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL lin_sequence: %0d bad, first at %0d", bad, first);
        end
        checks++;
        if (got_addr.size() != 12 || got_addr[11] != 11 || !got_fl[11] || got_fl[10]) begin
            errors++; $display("FAIL lin_frame_last: frame_last not on addr 11 only");
        end
        checks++;
        if (done_at_end !== 1'b1 || done_extra != 0) begin
            errors++;
            $display("FAIL lin_done: at_end=%b extra=%0d want 1 0", done_at_end, done_extra);
        end
    endtask

    task automatic test_random_adv();
        int lat, bad, first;
        do_start(1'b0, 2, 1, 1);
        wait_vld(lat);
        checks++;
        if (lat != 3 || n_points_o !== 12'd60) begin
            errors++; $display("FAIL rnd_start: lat=%0d n=%0d want 3 60", lat, n_points_o);
        end
        collect(1'b1, 3000);
        gen_expected(1'b0, 2, 1, 1);
        checks++;
        if (timed_out || got_addr.size() != 180) begin
            errors++; $display("FAIL rnd_count: got %0d want 180", got_addr.size());
        end
        seq_mismatch(bad, first);
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL rnd_sequence: %0d bad, first at %0d", bad, first);
        end
        checks++;
        if (hold_bad != 0) begin
            errors++; $display("FAIL rnd_hold: got %0d changes while stalled want 0", hold_bad);
        end
        checks++;
        if (done_at_end !== 1'b1 || done_extra != 0) begin
            errors++;
            $display("FAIL rnd_done: at_end=%b extra=%0d want 1 0", done_at_end, done_extra);
        end
    endtask

    task automatic test_abort();
        int lat, k, n3, dcnt, bad, first;
        do_start(1'b0, 2, 1, 1);
        wait_vld(lat);
        adv_i = 1'b1;
        k = 0; n3 = 0;
        while (k < 300 && n3 < 3) begin
            @(negedge clk);
            k++;
            if (pass_radix_o == 2'b10) n3++;
        end
        checks++;
        if (n3 < 3) begin
            errors++; $display("FAIL abort_reach_r3: got %0d radix-3 cycles want 3", n3);
        end
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        adv_i   = 1'b0;
        checks++;
        if (addr_vld_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0 || cfg_err_o !== 1'b0)
        begin
            errors++;
            $display("FAIL abort_stop: vld=%b busy=%b done=%b cfg=%b want 0000", addr_vld_o,
                     busy_o, done_o, cfg_err_o);
        end
        dcnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (done_o || busy_o || addr_vld_o) dcnt++;
        end
        checks++;
        if (dcnt != 0) begin
            errors++; $display("FAIL abort_quiet: got %0d active cycles want 0", dcnt);
        end
        do_start(1'b0, 0, 0, 1);
        wait_vld(lat);
        checks++;
        if (lat != 2 || addr_o !== '0 || pass_radix_o !== 2'b01 || n_points_o !== 12'd5) begin
            errors++;
            $display("FAIL abort_restart: lat=%0d addr=%0d rad=%0d n=%0d want 2 0 1 5", lat,
                     addr_o, pass_radix_o, n_points_o);
        end
        collect(1'b0, 100);
        gen_expected(1'b0, 0, 0, 1);
        seq_mismatch(bad, first);
        checks++;
        if (timed_out || got_addr.size() != 5 || bad != 0 || done_at_end !== 1'b1) begin
            errors++;
            $display("FAIL abort_new_frame: count=%0d bad=%0d done=%b want 5 0 1",
                     got_addr.size(), bad, done_at_end);
        end
    endtask

    task automatic test_rst_mid_run();
        int lat, act, bad, first;
        do_start(1'b0, 1, 1, 1);
        wait_vld(lat);
        adv_i = 1'b1;
        repeat (10) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({addr_o, addr_vld_o, pass_radix_o, pass_last_o, frame_last_o, busy_o, done_o,
             cfg_err_o, n_points_o} !== '0) begin
            errors++;
            $display("FAIL rst_async: addr=%0d vld=%b rad=%0d busy=%b n=%0d want all 0",
                     addr_o, addr_vld_o, pass_radix_o, busy_o, n_points_o);
        end
        @(negedge clk);
        rst   = 1'b0;
        adv_i = 1'b0;
        act = 0;
        repeat (4) begin
            @(negedge clk);
            if (done_o || busy_o || addr_vld_o) act++;
        end
        checks++;
        if (act != 0) begin
            errors++; $display("FAIL rst_idle: got %0d active cycles want 0", act);
        end
        do_start(1'b1, 1, 0, 0);
        wait_vld(lat);
        collect(1'b0, 50);
        gen_expected(1'b1, 1, 0, 0);
        seq_mismatch(bad, first);
        checks++;
        if (timed_out || got_addr.size() != 2 || bad != 0 || done_at_end !== 1'b1) begin
            errors++;
            $display("FAIL rst_restart: count=%0d bad=%0d done=%b want 2 0 1", got_addr.size(),
                     bad, done_at_end);
        end
    endtask

    task automatic test_back_to_back();
        int lat, k, act;
        do_start(1'b1, 1, 0, 0);
        wait_vld(lat);
        adv_i = 1'b1;
        k = 0;
        while (!done_o && k < 50) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (done_o !== 1'b1) begin
            errors++; $display("FAIL b2b_done: got %b want 1", done_o);
        end
        adv_i   = 1'b0;
        start_i = 1'b1;
        mode_i  = 1'b1;
        e2_i    = E2_W'(2);
        @(negedge clk);
        start_i = 1'b0;
        act = 0;
        repeat (4) begin
            if (busy_o || addr_vld_o) act++;
            @(negedge clk);
        end
        checks++;
        if (act != 0) begin
            errors++; $display("FAIL b2b_ignored: got %0d active cycles want 0", act);
        end
        do_start(1'b1, 1, 0, 0);
        checks++;
        if (busy_o !== 1'b1) begin
            errors++; $display("FAIL b2b_accept: busy got %b want 1", busy_o);
        end
        wait_vld(lat);
        collect(1'b0, 50);
        checks++;
        if (timed_out || got_addr.size() != 2 || done_at_end !== 1'b1) begin
            errors++;
            $display("FAIL b2b_frame: count=%0d done=%b want 2 1", got_addr.size(), done_at_end);
        end
    endtask

    initial begin
        rst     = 1'b1;
        start_i = 1'b0;
        mode_i  = 1'b0;
        adv_i   = 1'b0;
        abort_i = 1'b0;
        e2_i    = '0;
        e3_i    = '0;
        e5_i    = '0;
        #3;
        test_reset();
        test_mode0_n30();
        test_cfg_err();
        test_linear();
        test_random_adv();
        test_abort();
        test_rst_mid_run();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mixed_radix_addr_seq.md
MIXED_RADIX_ADDR_SEQ -- requirements
Module: mixed_radix_addr_seq

Interface
REQ-001 Parameter: ADDR_W, 11, address width; supported frame size N <= 2^ADDR_W.
REQ-002 Parameter: E2_W, 4, width of radix-2 exponent input.
REQ-003 Parameter: E3_W, 3, width of radix-3 exponent input.
REQ-004 Parameter: E5_W, 2, width of radix-5 exponent input.
REQ-005 Reset is rst (asynchronous, active-high); the clock is clk.
REQ-006 Port: clk  in  1  clock.
REQ-007 Port: rst  in  1  asynchronous active-high reset.
REQ-008 Port: start  in  1  single-cycle frame request.
REQ-009 Port: mode  in  1  0 = stride-permuted radix passes; 1 = natural linear pass.
REQ-010 Port: e2 / e3 / e5  in  E2_W / E3_W / E5_W  radix exponents; N = 2^e2 * 3^e3 * 5^e5.
REQ-011 Port: adv  in  1  consumer accepts the current address.
REQ-012 Port: abort  in  1  cancels the frame.
REQ-013 Port: addr  out  ADDR_W  current address.
REQ-014 Port: addr_vld  out  1  addr is valid.
REQ-015 Port: pass_radix  out  2  current pass: 00 = linear, 01 = radix-5, 10 = radix-3, 11 = radix-2.
REQ-016 Port: pass_last / frame_last  out  1 / 1  current address is the last of its pass / of the frame.
REQ-017 Port: busy / done / cfg_err  out  1 / 1 / 1  frame active / completion pulse / configuration rejected.
REQ-018 Port: n_points  out  ADDR_W+1  latched N.

Function
REQ-019 FSM states: IDLE, CALC, PROD, RUN; all outputs are registered.
REQ-020 In IDLE, a start sampled high latches mode, e2, e3 and e5 and moves the FSM to CALC; start while busy=1 is ignored.
REQ-021 CALC: P2, P3 and P5 each start at 1 and are multiplied by 2, 3 and 5 respectively, one factor per cycle, until each exponent is exhausted; CALC lasts max(e2,e3,e5,1) cycles.
REQ-022 PROD (1 cycle): N = P2*P3*P5; strides M5 = P3*P2, M3 = P5*P2, M2 = P5*P3; n_points <= N.
REQ-023 PROD, N < 2 or N > 2^ADDR_W: cfg_err pulses for 1 cycle; the FSM returns to IDLE; addr_vld is never asserted.
REQ-024 PROD, valid N: the FSM enters RUN; addr_vld rises exactly max(e2,e3,e5,1)+1 cycles after the start-sampling edge.
REQ-025 Pass order, mode 0: radix-5, then radix-3, then radix-2; any pass whose exponent is 0 is skipped.
REQ-026 Pass order, mode 1: a single pass with pass_radix=00 and addr = 0..N-1.
REQ-027 Pass address order (mode 0), pass with P = r^e and stride M = N/P: outer index x = 0..M-1, inner c = 0..P-1, addr = x + c*M.
REQ-028 Address generation is incremental: +M per inner step; at inner wrap, reset to x+1; no multiplier in the address path.
REQ-029 Handshake: addr advances only on a cycle with addr_vld=1 and adv=1; with adv=0, addr, pass_radix, pass_last and frame_last hold.
REQ-030 pass_last is high on inner index P-1 with outer index M-1; frame_last is high on pass_last of the final pass.
REQ-031 Acceptance of the frame_last address: done pulses 1 cycle on the next edge, together with addr_vld=0, busy=0 and FSM=IDLE.
REQ-032 Abort in any non-IDLE state: the next edge sets FSM=IDLE, addr_vld=0 and busy=0; done and cfg_err are not asserted.
REQ-033 abort has priority over adv in the same cycle.
REQ-034 A start and a done in the same cycle: the start is ignored; the next start in IDLE is accepted.
REQ-035 busy is high from the edge after start is accepted through the cycle of the final acceptance.
REQ-036 n_points holds the last valid N until the next PROD.

Reset
REQ-037 rst=1 forces state IDLE and sets all outputs to 0, including addr, n_points and pass_radix.
REQ-038 rst asserted mid-frame aborts the frame immediately; no done pulse follows deassertion.

Verification
REQ-039 Scenario: e5=1, e3=1, e2=1, mode 0, adv=1 -> 90 addresses, N=30. Radix-5 pass: 0,6,12,18,24,1,7,... Radix-3 pass: 0,10,20,1,11,... Radix-2 pass: 0,15,1,16,...,14,29. Single done pulse.
REQ-040 Scenario: e2=9, e3=2 -> N=4608 > 2048 -> cfg_err for 1 cycle, no addr_vld, busy low afterwards.
REQ-041 Scenario: e2=2, e3=1, mode 1 -> addr 0..11, pass_radix=00, frame_last on addr 11.
REQ-042 Scenario: adv toggled randomly during a 60-point frame -> no address skipped or duplicated; outputs hold while adv=0.
REQ-043 Scenario: abort in the radix-3 pass, then start with e5=1 -> no done from the aborted frame; new sequence starts at addr 0 with pass_radix=01.
REQ-044 Scenario: rst pulse mid-RUN -> all outputs 0 asynchronously; IDLE after release; start accepted next.
